// File: rtl/ex_flags_stage.sv
// ex_flags_stage
//   EX/MEM pipeline register plus NZCV flag register and B.cond resolution.
//
//   Ports:
//     clk          system clock, rising edge
//     reset        asynchronous, active-low clear of all state
//     ex_valid     EX instruction valid
//     ex_result    N-bit adder sum from EX
//     of_flag      adder signed overflow (V)
//     co_flag      adder carry out (C)
//     set_flags    EX instruction writes NZCV
//     is_bcond     EX instruction is a conditional branch
//     cond         4-bit branch condition code
//     stall        hold the EX/MEM boundary this cycle
//     flush        kill the EX instruction this cycle (beats stall)
//     mem_valid    registered valid into MEM
//     mem_result   registered result into MEM
//     flags_nzcv   architectural flags {N,Z,C,V}
//     take_branch  combinational branch decision from the registered flags
module ex_flags_stage #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_valid,
  input  logic [N-1:0] ex_result,
  input  logic         of_flag,
  input  logic         co_flag,
  input  logic         set_flags,
  input  logic         is_bcond,
  input  logic [3:0]   cond,
  input  logic         stall,
  input  logic         flush,
  output logic         mem_valid,
  output logic [N-1:0] mem_result,
  output logic [3:0]   flags_nzcv,
  output logic         take_branch
);

  logic         mem_valid_q,  mem_valid_d;
  logic [N-1:0] mem_result_q, mem_result_d;
  logic [3:0]   flags_q,      flags_d;

  logic       commit;
  logic [3:0] new_flags;
  logic       f_n, f_z, f_c, f_v;
  logic       cond_true;

  // Flags produced by the current EX instruction and the commit qualifier.
  always_comb begin
    new_flags = {ex_result[N-1], (ex_result == '0), co_flag, of_flag};
    commit    = ex_valid & set_flags & ~stall & ~flush;
  end

  // Next-state: flush clears the MEM slot, stall holds it, otherwise advance.
  // Result data is loaded regardless of ex_valid; consumers qualify it.
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_result_d = mem_result_q;
    flags_d      = flags_q;
    if (flush) begin
      mem_valid_d  = 1'b0;
      mem_result_d = '0;
    end else if (!stall) begin
      mem_valid_d  = ex_valid;
      mem_result_d = ex_result;
    end
    if (commit) begin
      flags_d = new_flags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid_q  <= 1'b0;
      mem_result_q <= '0;
      flags_q      <= '0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_result_q <= mem_result_d;
      flags_q      <= flags_d;
    end
  end

  // Branch decision uses the registered flags, so a setter in the previous
  // cycle is visible and the same-cycle adder flags never are.
  always_comb begin
    {f_n, f_z, f_c, f_v} = flags_q;
    cond_true = 1'b1;
    case (cond)
      4'b0000: cond_true = f_z;
      4'b0001: cond_true = ~f_z;
      4'b0010: cond_true = f_c;
      4'b0011: cond_true = ~f_c;
      4'b0100: cond_true = f_n;
      4'b0101: cond_true = ~f_n;
      4'b0110: cond_true = f_v;
      4'b0111: cond_true = ~f_v;
      4'b1000: cond_true = f_c & ~f_z;
      4'b1001: cond_true = ~f_c | f_z;
      4'b1010: cond_true = (f_n == f_v);
      4'b1011: cond_true = (f_n != f_v);
      4'b1100: cond_true = ~f_z & (f_n == f_v);
      4'b1101: cond_true = f_z | (f_n != f_v);
      default: cond_true = 1'b1;
    endcase
    take_branch = ex_valid & is_bcond & ~flush & cond_true;
  end

  assign mem_valid  = mem_valid_q;
  assign mem_result = mem_result_q;
  assign flags_nzcv = flags_q;

endmodule

// File: tb/tb_ex_flags_stage.sv
// Testbench for ex_flags_stage: directed vectors with hand-computed expected
// values pushed to a scoreboard queue; a monitor pops and compares per cycle.
module tb_ex_flags_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_result;
  logic        of_flag;
  logic        co_flag;
  logic        set_flags;
  logic        is_bcond;
  logic [3:0]  cond;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [63:0] mem_result;
  logic [3:0]  flags_nzcv;
  logic        take_branch;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    string       nm;
    logic        tb;
    logic        mv;
    logic [63:0] mr;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb_q[$];

  ex_flags_stage #(.N(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_result  (ex_result),
    .of_flag    (of_flag),
    .co_flag    (co_flag),
    .set_flags  (set_flags),
    .is_bcond   (is_bcond),
    .cond       (cond),
    .stall      (stall),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .mem_result (mem_result),
    .flags_nzcv (flags_nzcv),
    .take_branch(take_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference condition table.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Monitor: take_branch sampled just before the edge, registers just after.
  initial begin : monitor
    exp_t  e;
    logic  tb_s;
    forever begin
      @(negedge clk);
      #4;
      tb_s = take_branch;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.nm, ".take_branch"}, {63'd0, tb_s},   {63'd0, e.tb});
        check({e.nm, ".mem_valid"},   {63'd0, mem_valid}, {63'd0, e.mv});
        check({e.nm, ".mem_result"},  mem_result,      e.mr);
        check({e.nm, ".flags"},       {60'd0, flags_nzcv}, {60'd0, e.fl});
      end
    end
  end

  // Drive one cycle (called at a falling edge) and queue its expectations.
  task automatic step(input string nm,
                      input logic ev, input logic [63:0] res, input logic of, input logic co,
                      input logic sf, input logic bc, input logic [3:0] cnd,
                      input logic st, input logic fl,
                      input logic e_tb, input logic e_mv, input logic [63:0] e_mr,
                      input logic [3:0] e_fl);
    exp_t e;
    ex_valid = ev; ex_result = res; of_flag = of; co_flag = co;
    set_flags = sf; is_bcond = bc; cond = cnd; stall = st; flush = fl;
    e.nm = nm; e.tb = e_tb; e.mv = e_mv; e.mr = e_mr; e.fl = e_fl;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

  initial begin : driver
    logic [63:0] res;
    logic [3:0]  f;
    reset = 1'b0;
    ex_valid = 0; ex_result = '0; of_flag = 0; co_flag = 0;
    set_flags = 0; is_bcond = 0; cond = 4'h0; stall = 0; flush = 0;
    #2;
    check("rst.mem_valid",  {63'd0, mem_valid},  64'd0);
    check("rst.mem_result", mem_result,          64'd0);
    check("rst.flags",      {60'd0, flags_nzcv}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    //    name        ev res              of co sf bc cond  st fl  tb mv mr      fl
    step("zero_carry", 1, 64'd0,           0, 1, 1, 0, 4'h0, 0, 0,  0, 1, 64'd0,  4'b0110);
    step("neg_ovf",    1, MSB,             1, 0, 1, 0, 4'h0, 0, 0,  0, 1, MSB,    4'b1001);
    step("b_ge",       1, 64'd0,           0, 0, 0, 1, 4'hA, 0, 0,  1, 1, 64'd0,  4'b1001);
    step("b_lt",       1, 64'd3,           0, 0, 0, 1, 4'hB, 0, 0,  0, 1, 64'd3,  4'b1001);
    for (int i = 0; i < 3; i++)
      step("stall",    1, 64'd5,           0, 1, 1, 1, 4'h4, 1, 0,  1, 1, 64'd3,  4'b1001);
    step("unstall",    1, 64'd5,           0, 1, 1, 0, 4'h0, 0, 0,  0, 1, 64'd5,  4'b0010);
    step("stall_flush",1, 64'd7,           1, 0, 1, 1, 4'hE, 1, 1,  0, 0, 64'd0,  4'b0010);
    step("invalid",    0, 64'd9,           0, 0, 1, 1, 4'hE, 0, 0,  0, 0, 64'd9,  4'b0010);
    step("setz",       1, 64'd0,           0, 0, 1, 0, 4'h0, 0, 0,  0, 1, 64'd0,  4'b0100);
    step("b_eq_next",  1, 64'd1,           0, 0, 0, 1, 4'h0, 0, 0,  1, 1, 64'd1,  4'b0100);
    step("flush_only", 1, 64'h10,          0, 1, 1, 1, 4'hF, 0, 1,  0, 0, 64'd0,  4'b0100);
    step("pre_rst",    1, MSB | 64'd1,     1, 1, 1, 0, 4'h0, 0, 0,  0, 1, MSB | 64'd1, 4'b1011);

    // Asynchronous reset asserted mid-cycle with state loaded.
    ex_valid = 1; is_bcond = 1; cond = 4'h1; set_flags = 0; stall = 0; flush = 0;
    #2;
    reset = 1'b0;
    #1;
    check("arst.mem_valid",  {63'd0, mem_valid},  64'd0);
    check("arst.mem_result", mem_result,          64'd0);
    check("arst.flags",      {60'd0, flags_nzcv}, 64'd0);
    check("arst.tb_ne",      {63'd0, take_branch}, 64'd1);
    cond = 4'h0;
    #1;
    check("arst.tb_eq",      {63'd0, take_branch}, 64'd0);
    set_flags = 1; ex_result = MSB; stall = 1;
    @(posedge clk);
    #1;
    check("arst_hold.mem_valid", {63'd0, mem_valid},  64'd0);
    check("arst_hold.flags",     {60'd0, flags_nzcv}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step("post_rst",   1, 64'h2A,          0, 0, 0, 0, 4'h0, 0, 0,  0, 1, 64'h2A, 4'b0000);

    // Condition sweep. N=1 with Z=1 cannot be produced by a real result,
    // so only the 12 reachable flag values are exercised.
    for (int fi = 0; fi < 16; fi++) begin
      f = fi[3:0];
      if (f[3] && f[2]) continue;
      res = f[3] ? MSB : (f[2] ? 64'd0 : 64'd1);
      step("sweep_set", 1, res, f[0], f[1], 1, 0, 4'h0, 0, 0, 0, 1, res, f);
      for (int c = 0; c < 16; c++)
        step($sformatf("sweep_f%0h_c%0h", f, c), 1, 64'(c), 0, 0, 0, 1, c[3:0], 0, 0,
             ref_cond(f, c[3:0]), 1, 64'(c), f);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
